// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU macro-op sequencer.
// Holds the macro-op encoding, ALU select codes, microcode operand-source and
// destination encodings, per-op step counts and the microcode entry record.
// Configuration: ALU_SEQ_XOR_EN selects XOR (7 steps) for op 111; INC (1 step) otherwise.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOT  = 3'b010,
        OP_PASS = 3'b011,
        OP_SUB  = 3'b100,
        OP_NEG  = 3'b101,
        OP_OR   = 3'b110,
        OP_EXT  = 3'b111   // XOR or INC depending on build
    } op_e;

    // ALU select codes
    localparam logic [1:0] SEL_ADD  = 2'b00;
    localparam logic [1:0] SEL_AND  = 2'b01;
    localparam logic [1:0] SEL_NOT  = 2'b10;
    localparam logic [1:0] SEL_PASS = 2'b11;

    typedef enum logic [2:0] {
        SRC_RA,
        SRC_RB,
        SRC_T,
        SRC_U,
        SRC_ONE,
        SRC_ZERO
    } src_e;

    typedef enum logic [1:0] {
        DST_T,
        DST_U,
        DST_RES
    } dst_e;

    // Micro-steps per macro-op
    localparam int unsigned STEPS_ADD  = 1;
    localparam int unsigned STEPS_AND  = 1;
    localparam int unsigned STEPS_NOT  = 1;
    localparam int unsigned STEPS_PASS = 1;
    localparam int unsigned STEPS_SUB  = 3;
    localparam int unsigned STEPS_NEG  = 2;
    localparam int unsigned STEPS_OR   = 4;
`ifdef ALU_SEQ_XOR_EN
    localparam int unsigned STEPS_EXT  = 7;
    localparam int unsigned STEP_W     = 3;
`else
    localparam int unsigned STEPS_EXT  = 1;
    localparam int unsigned STEP_W     = 2;
`endif

    typedef struct packed {
        logic [1:0] sel;
        src_e       a_src;
        src_e       b_src;
        dst_e       dest;
        logic       last;
    } ucode_t;

    // Index of the final micro-step of an op
    function automatic logic [STEP_W-1:0] op_last_step(op_e op);
        case (op)
            OP_ADD:  return STEP_W'(STEPS_ADD - 1);
            OP_AND:  return STEP_W'(STEPS_AND - 1);
            OP_NOT:  return STEP_W'(STEPS_NOT - 1);
            OP_PASS: return STEP_W'(STEPS_PASS - 1);
            OP_SUB:  return STEP_W'(STEPS_SUB - 1);
            OP_NEG:  return STEP_W'(STEPS_NEG - 1);
            OP_OR:   return STEP_W'(STEPS_OR - 1);
            default: return STEP_W'(STEPS_EXT - 1);
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_ucode.sv
// Combinational microcode table for the ALU macro-op sequencer.
// Ports:
//   op    in   macro-op being executed
//   step  in   current micro-step index
//   uc    out  {alu_sel, a_src, b_src, dest, last} for this step
// Configuration: ALU_SEQ_XOR_EN selects the XOR sequence for op 111, else INC.
module alu_seq_ucode
    import alu_seq_pkg::*;
(
    input  op_e                op,
    input  logic [STEP_W-1:0]  step,
    output ucode_t             uc
);

    function automatic ucode_t mk(logic [1:0] sel, src_e a, src_e b, dst_e d);
        ucode_t e;
        e.sel   = sel;
        e.a_src = a;
        e.b_src = b;
        e.dest  = d;
        e.last  = 1'b0;
        return e;
    endfunction

    // Table lookup; last is derived from the per-op step count
    always_comb begin
        uc = mk(SEL_PASS, SRC_ZERO, SRC_ZERO, DST_RES);
        case (op)
            OP_ADD:  uc = mk(SEL_ADD,  SRC_RA, SRC_RB,   DST_RES);
            OP_AND:  uc = mk(SEL_AND,  SRC_RA, SRC_RB,   DST_RES);
            OP_NOT:  uc = mk(SEL_NOT,  SRC_RA, SRC_ZERO, DST_RES);
            OP_PASS: uc = mk(SEL_PASS, SRC_RA, SRC_ZERO, DST_RES);
            OP_SUB: begin
                case (step)
                    STEP_W'(0): uc = mk(SEL_NOT, SRC_RB, SRC_ZERO, DST_T);
                    STEP_W'(1): uc = mk(SEL_ADD, SRC_T,  SRC_ONE,  DST_T);
                    STEP_W'(2): uc = mk(SEL_ADD, SRC_RA, SRC_T,    DST_RES);
                    default: ;
                endcase
            end
            OP_NEG: begin
                case (step)
                    STEP_W'(0): uc = mk(SEL_NOT, SRC_RA, SRC_ZERO, DST_T);
                    STEP_W'(1): uc = mk(SEL_ADD, SRC_T,  SRC_ONE,  DST_RES);
                    default: ;
                endcase
            end
            OP_OR: begin
                case (step)
                    STEP_W'(0): uc = mk(SEL_NOT, SRC_RA, SRC_ZERO, DST_T);
                    STEP_W'(1): uc = mk(SEL_NOT, SRC_RB, SRC_ZERO, DST_U);
                    STEP_W'(2): uc = mk(SEL_AND, SRC_T,  SRC_U,    DST_T);
                    STEP_W'(3): uc = mk(SEL_NOT, SRC_T,  SRC_ZERO, DST_RES);
                    default: ;
                endcase
            end
            default: begin
`ifdef ALU_SEQ_XOR_EN
                // XOR = OR(a,b) & NAND(a,b)
                case (step)
                    STEP_W'(0): uc = mk(SEL_NOT, SRC_RA, SRC_ZERO, DST_T);
                    STEP_W'(1): uc = mk(SEL_NOT, SRC_RB, SRC_ZERO, DST_U);
                    STEP_W'(2): uc = mk(SEL_AND, SRC_T,  SRC_U,    DST_T);
                    STEP_W'(3): uc = mk(SEL_NOT, SRC_T,  SRC_ZERO, DST_T);
                    STEP_W'(4): uc = mk(SEL_AND, SRC_RA, SRC_RB,   DST_U);
                    STEP_W'(5): uc = mk(SEL_NOT, SRC_U,  SRC_ZERO, DST_U);
                    STEP_W'(6): uc = mk(SEL_AND, SRC_T,  SRC_U,    DST_RES);
                    default: ;
                endcase
`else
                uc = mk(SEL_ADD, SRC_RA, SRC_ONE, DST_RES);
`endif
            end
        endcase
        uc.last = (step == op_last_step(op));
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller that runs extended macro-ops (SUB, NEG, OR, INC/XOR)
// on a 16-bit four-function ALU, one micro-step per cycle.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   start, op, A, B   request, macro-op code and operands (accepted when idle)
//   busy, done        in-flight flag, one-cycle completion pulse
//   result            last completed result
//   alu_a, alu_b      ALU operand drive (combinational)
//   alu_sel           ALU select (combinational)
//   alu_out           ALU combinational output
// Configuration: define ALU_SEQ_XOR_EN to make op 111 XOR; otherwise it is INC.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    state_e            state;
    logic [STEP_W-1:0] step;
    op_e               op_q;
    logic [DATA_W-1:0] ra, rb, t, u;
    ucode_t            uc;

    alu_seq_ucode u_ucode (
        .op   (op_q),
        .step (step),
        .uc   (uc)
    );

    function automatic logic [DATA_W-1:0] pick(src_e s, logic [DATA_W-1:0] ra_v,
                                               logic [DATA_W-1:0] rb_v,
                                               logic [DATA_W-1:0] t_v,
                                               logic [DATA_W-1:0] u_v);
        case (s)
            SRC_RA:  return ra_v;
            SRC_RB:  return rb_v;
            SRC_T:   return t_v;
            SRC_U:   return u_v;
            SRC_ONE: return DATA_W'(1);
            default: return '0;
        endcase
    endfunction

    // Operand muxes; idle drives a neutral PASS of zero
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = SEL_PASS;
        if (state == S_EXEC) begin
            alu_sel = uc.sel;
            alu_a   = pick(uc.a_src, ra, rb, t, u);
            alu_b   = pick(uc.b_src, ra, rb, t, u);
        end
    end

    // Control FSM, step counter and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_IDLE;
            step   <= '0;
            op_q   <= OP_ADD;
            ra     <= '0;
            rb     <= '0;
            t      <= '0;
            u      <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_EXEC;
                        busy  <= 1'b1;
                        op_q  <= op_e'(op);
                        ra    <= A;
                        rb    <= B;
                        step  <= '0;
                    end
                end
                S_EXEC: begin
                    case (uc.dest)
                        DST_T:   t      <= alu_out;
                        DST_U:   u      <= alu_out;
                        DST_RES: result <= alu_out;
                        default: ;
                    endcase
                    if (uc.last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
